// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain stage for a synchronous FIFO. Pops one word at a time through the FIFO
//   read port and serialises it as a UART frame: start bit (0), WIDTH data bits
//   LSB first, optional even-parity bit, stop bit (1). Same clock as the FIFO.
//
// Build option:
//   FIFO_UART_TX_PARITY_EN  when defined, an even-parity bit (^word) is sent
//                           between the last data bit and the stop bit.
//
// Parameters:
//   WIDTH         data word width (matches the FIFO width)
//   CLKS_PER_BIT  clk cycles per serial bit, >= 2
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-low reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO read strobe, one cycle per word
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   tx            serial line, idles high
//   busy          high whenever the FSM is not idle
//   tx_done       one-cycle pulse in the last cycle of each stop bit
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // tx_done is registered, so it is set one cycle before the last stop cycle.
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e             state_q;
  logic [BAUD_W-1:0]  baud_q;
  logic [BIT_W-1:0]   bit_q;
  logic [WIDTH-1:0]   shift_q;
  logic               tx_q;
  logic               rd_en_q;
  logic               busy_q;
  logic               done_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic               parity_q;
`endif

  logic               baud_wrap;
  logic [WIDTH-1:0]   shift_next;

  assign baud_wrap  = (baud_q == BAUD_LAST);
  // Bit that goes on the line after the current one is shifted out.
  assign shift_next = shift_q >> 1;

  // NOTE: every register in this block is updated with <= so all of them
  // see the pre-edge values of each other; blocking = here would create
  // order-dependent behaviour and simulation/synthesis mismatches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: single-cycle strobes default low each cycle and are raised only
      // by the state that owns them, so they can never stick high.
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (!fifo_empty) begin
            state_q <= S_FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        // Read strobe is high during this state; data arrives next cycle.
        S_FETCH: state_q <= S_LOAD;

        S_LOAD: begin
          shift_q  <= fifo_rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q <= ^fifo_rd_data;
`endif
          tx_q     <= 1'b0;
          state_q  <= S_START;
        end

        S_START: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            shift_q <= shift_next;
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shift_next[0];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (baud_q == BAUD_PRE) begin
            done_q <= 1'b1;
          end
          if (baud_wrap) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Self-checking bench for fifo_uart_tx (WIDTH=8, CLKS_PER_BIT=4). A queue
//   models the upstream FIFO; a line monitor decodes every frame by sampling
//   tx mid-bit and the directed sequence compares decoded frames and event
//   timing against values worked out from the frame format.
//   Build with FIFO_UART_TX_PARITY_EN to exercise the parity build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_uart_tx;

  localparam int W = 8;
  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB    = W + 2 + PAR;   // bits per frame
  localparam int FRAME = NB * C;        // cycles per frame

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_rd_data = '0;
  logic         tx;
  logic         busy;
  logic         tx_done;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- upstream FIFO model ----------------
  logic [W-1:0] fq[$];
  int           underflow = 0;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() == 0) underflow++;
      else fifo_rd_data <= fq.pop_front();
    end else begin
      // Garbage outside the valid cycle: must never reach the line.
      fifo_rd_data <= W'($urandom);
    end
    fifo_empty <= (fq.size() == 0);
  end

  // ---------------- line monitor ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         start_b;
    logic         par_b;
    logic         stop_b;
    int           start_cyc;
    int           done_k;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  bit     mon_active = 1'b0;
  int     mon_k = 0;
  logic   prev_tx = 1'b1;
  int     rd_cnt = 0, done_cnt = 0, last_rd_cyc = 0, last_done_cyc = 0;
  int     viol = 0, busy_bad = 0;

  always @(negedge clk) begin
    int bi;
    if (!rst) begin
      mon_active = 1'b0;
    end else begin
      if (fifo_rd_en === 1'b1) begin
        rd_cnt++;
        last_rd_cyc = cyc;
        if (fifo_empty) viol++;
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (!mon_active && prev_tx === 1'b1 && tx === 1'b0) begin
        mon_active    = 1'b1;
        mon_k         = 0;
        cur.data      = '0;
        cur.start_b   = 1'b1;
        cur.par_b     = 1'b0;
        cur.stop_b    = 1'b0;
        cur.start_cyc = cyc;
        cur.done_k    = -1;
      end
      if (mon_active) begin
        if (busy !== 1'b1) busy_bad++;
        if (tx_done === 1'b1 && cur.done_k < 0) cur.done_k = mon_k;
        if (mon_k % C == C / 2) begin
          bi = mon_k / C;
          if (bi == 0)            cur.start_b     = tx;
          else if (bi <= W)       cur.data[bi-1]  = tx;
          else if (bi == NB - 1)  cur.stop_b      = tx;
          else                    cur.par_b       = tx;
        end
        if (mon_k == FRAME - 1) begin
          frames.push_back(cur);
          mon_active = 1'b0;
        end else begin
          mon_k++;
        end
      end
    end
    prev_tx = tx;
  end

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
  endtask

  // Wait until the monitor is at least kk cycles into a frame.
  task automatic wait_k(input int kk, input string tag);
    int n = 0;
    while (!(mon_active && mon_k >= kk) && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, 32'(n < 500), 32'd1);
  endtask

  // Wait for the next decoded frame and compare it with the expected word.
  // Returns in the cycle carrying tx_done of that frame.
  task automatic expect_frame(input logic [W-1:0] w, input string tag, output int start_c);
    frame_t f;
    int n = 0;
    start_c = 0;
    while (frames.size() == 0 && n < 1000) begin
      tick();
      n++;
    end
    check({tag, "_arrive"}, 32'(frames.size() != 0), 32'd1);
    if (frames.size() != 0) begin
      f = frames.pop_front();
      check({tag, "_data"},     32'(f.data),    32'(w));
      check({tag, "_startbit"}, 32'(f.start_b), 32'd0);
      check({tag, "_stopbit"},  32'(f.stop_b),  32'd1);
`ifdef FIFO_UART_TX_PARITY_EN
      check({tag, "_parity"},   32'(f.par_b),   32'($countones(w) % 2));
`endif
      check({tag, "_done_pos"}, 32'(f.done_k),  32'(FRAME - 1));
      start_c = f.start_cyc;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p, s0, s1, s2, s3, rd0, bad, d;
    logic [W-1:0] rw[$];

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("rst_tx",      32'(tx),         32'd1);
    check("rst_busy",    32'(busy),       32'd0);
    check("rst_rd_en",   32'(fifo_rd_en), 32'd0);
    check("rst_tx_done", 32'(tx_done),    32'd0);
    rst = 1'b1;
    tick();

    // Empty FIFO for 100 cycles: line idle, no pops
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
    end
    check("idle_bad_cycles", 32'(bad),           32'd0);
    check("idle_rd_cnt",     32'(rd_cnt),        32'd0);
    check("idle_frames",     32'(frames.size()), 32'd0);

    // Single word 8'hA5: latency, bits, frame length
    p = cyc;
    push(8'hA5);
    expect_frame(8'hA5, "a5", s0);
    check("a5_rd_latency", 32'(last_rd_cyc - p), 32'd2);
    check("a5_tx_latency", 32'(s0 - p),          32'd4);
    check("a5_rd_cnt",     32'(rd_cnt),          32'd1);
    check("a5_done_cnt",   32'(done_cnt),        32'd1);
    repeat (10) tick();

    // Back-to-back 01,02,03; FIFO empties during the last stop bit
    rd0 = rd_cnt;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    expect_frame(8'h01, "b1", s1);
    expect_frame(8'h02, "b2", s2);
    check("b_period_12", 32'(s2 - s1), 32'(FRAME + 3));
    expect_frame(8'h03, "b3", s3);
    check("b_period_23", 32'(s3 - s2), 32'(FRAME + 3));
    check("b3_busy_at_done", 32'(busy),    32'd1);
    check("b3_done_pulse",   32'(tx_done), 32'd1);
    tick();
    check("b3_busy_after", 32'(busy), 32'd0);
    check("b3_tx_after",   32'(tx),   32'd1);
    repeat (20) tick();
    check("b_rd_cnt",   32'(rd_cnt - rd0),   32'd3);
    check("b_done_cnt", 32'(done_cnt),       32'd4);
    check("b_leftover", 32'(frames.size()), 32'd0);

    // Refill during STOP: next pop still goes through IDLE
    push(8'h5A);
    wait_k(FRAME - C + 1, "refill");
    push(8'hC3);
    expect_frame(8'h5A, "r1", s0);
    d = cyc;
    expect_frame(8'hC3, "r2", s1);
    check("refill_rd_latency", 32'(last_rd_cyc - d), 32'd2);
    check("refill_period",     32'(s1 - s0),         32'(FRAME + 3));

    // Randomised bursts against the word queue
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 3);
      rw.delete();
      for (int j = 0; j < n; j++) begin
        logic [W-1:0] w;
        w = W'($urandom);
        push(w);
        rw.push_back(w);
      end
      foreach (rw[j]) expect_frame(rw[j], "rand", s0);
      repeat ($urandom_range(0, 15)) tick();
    end

    // Reset in DATA bit 3 of 8'hFF: discarded, next word goes out
    push(8'hFF);
    push(8'h3C);
    wait_k(17, "rst_data");
    rd0 = rd_cnt;
    rst = 1'b0;
    #1;
    check("rstd_tx",    32'(tx),         32'd1);
    check("rstd_busy",  32'(busy),       32'd0);
    check("rstd_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    expect_frame(8'h3C, "after_rst", s0);
    repeat (10) tick();
    check("after_rst_rd_cnt", 32'(rd_cnt - rd0), 32'd1);

    // Reset in START (line low): tx must rise without a clock edge
    push(W'($urandom));
    wait_k(1, "rst_start");
    rd0 = rd_cnt;
    check("rsts_tx_before", 32'(tx), 32'd0);
    rst = 1'b0;
    #1;
    check("rsts_tx",   32'(tx),   32'd1);
    check("rsts_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    repeat (60) tick();
    check("rsts_no_frame", 32'(frames.size()), 32'd0);
    check("rsts_no_pop",   32'(rd_cnt - rd0),  32'd0);

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity: 8'h07 -> 1, 8'h03 -> 0
    push(8'h07);
    expect_frame(8'h07, "par07", s0);
    push(8'h03);
    expect_frame(8'h03, "par03", s1);
`endif

    // Global invariants collected by the monitor
    check("no_underflow",      32'(underflow), 32'd0);
    check("no_rd_while_empty", 32'(viol),      32'd0);
    check("busy_in_frame",     32'(busy_bad),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
